// File: rtl/exp_golomb_decode_if.sv
// Handshake and data bundle for the exp-Golomb decoder.
// The bitstream producer and symbol consumer use the master side. The decoder uses the slave side.
interface exp_golomb_decode_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  k;
    logic        is_ac;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val;
    logic        sign;
    logic [31:0] codeword_length;
    logic        error;
    logic [6:0]  level;

    modport master (
        output in_word, in_valid, k, is_ac, out_ready,
        input  in_ready, out_valid, val, sign, codeword_length, error, level
    );

    modport slave (
        input  in_word, in_valid, k, is_ac, out_ready,
        output in_ready, out_valid, val, sign, codeword_length, error, level
    );
endinterface

// File: rtl/exp_golomb_decode.sv
// Exp-Golomb codeword decoder. It reads an MSB-first 32-bit word stream through a bit buffer
// and emits one magnitude, sign and length per symbol, with valid/ready on both sides.
module exp_golomb_decode #(
    parameter int MAX_Q = 16,
    parameter int BUF_W = 64
) (
    input logic               clk,
    input logic               reset,
    exp_golomb_decode_if.slave bus
);
    localparam int QW = $clog2(MAX_Q + 1);
    localparam int IW = $clog2(BUF_W);
    localparam int LW = 7;

    logic [BUF_W-1:0] r_buf;
    logic [LW-1:0]    r_level;
    logic             r_outValid;
    logic [31:0]      r_val;
    logic             r_sign;
    logic [31:0]      r_len;
    logic             r_error;

    logic             w_found;
    logic [QW-1:0]    w_q;
    logic [LW-1:0]    w_codeLen;
    logic [LW-1:0]    w_need;
    logic             w_complete;
    logic             w_errDetect;
    logic             w_fire;
    logic [31:0]      w_sum;
    logic [31:0]      w_val;
    logic [IW-1:0]    w_signIdx;
    logic             w_sign;
    logic [LW-1:0]    w_levelAfter;
    logic [LW-1:0]    w_levelNext;
    logic [BUF_W-1:0] w_shifted;
    logic [BUF_W-1:0] w_incoming;
    logic [BUF_W-1:0] w_bufNext;
    logic             w_inReady;
    logic             w_accept;

    // Bits below the valid region are always zero. The prefix scan can therefore
    // ignore level, and a 1 that it finds is always inside the valid bits.
    always_comb begin
        w_found = 1'b0;
        w_q     = '0;
        for (int i = MAX_Q; i >= 0; i--) begin
            if (r_buf[BUF_W-1-i]) begin
                w_found = 1'b1;
                w_q     = QW'(i);
            end
        end
    end

    assign w_codeLen   = LW'({w_q, 1'b0}) + LW'(bus.k) + LW'(1);
    assign w_need      = w_codeLen + LW'(bus.is_ac);
    assign w_complete  = w_found && (r_level >= w_need);
    assign w_errDetect = !w_found && (r_level >= LW'(MAX_Q + 1));
    assign w_fire      = w_complete && !r_error && (!r_outValid || bus.out_ready);

    // The leading zeros make the top codeLen bits numerically equal to the info field.
    assign w_sum     = 32'(r_buf >> (LW'(BUF_W) - w_codeLen));
    assign w_val     = w_sum - (32'd1 << bus.k);
    assign w_signIdx = IW'(LW'(BUF_W - 1) - w_codeLen);
    assign w_sign    = bus.is_ac & r_buf[w_signIdx];

    // A new word lands at the level that remains after this cycle's consumption.
    assign w_levelAfter = w_fire ? (r_level - w_need) : r_level;
    assign w_shifted    = w_fire ? (r_buf << w_need) : r_buf;
    assign w_inReady    = !r_error && (w_levelAfter <= LW'(32));
    assign w_accept     = bus.in_valid && w_inReady;
    assign w_incoming   = {bus.in_word, {(BUF_W-32){1'b0}}} >> w_levelAfter;
    assign w_bufNext    = w_accept ? (w_shifted | w_incoming) : w_shifted;
    assign w_levelNext  = w_levelAfter + (w_accept ? LW'(32) : LW'(0));

    // Buffer, level and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf   <= '0;
            r_level <= '0;
            r_error <= 1'b0;
        end else begin
            r_buf   <= w_bufNext;
            r_level <= w_levelNext;
            if (w_errDetect) begin
                r_error <= 1'b1;
            end
        end
    end

    // Output register. It holds its symbol until it is drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_val      <= '0;
            r_sign     <= 1'b0;
            r_len      <= '0;
        end else if (w_fire) begin
            r_outValid <= 1'b1;
            r_val      <= w_val;
            r_sign     <= w_sign;
            r_len      <= 32'(w_need);
        end else if (bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.in_ready        = w_inReady;
    assign bus.out_valid       = r_outValid;
    assign bus.val             = r_val;
    assign bus.sign            = r_sign;
    assign bus.codeword_length = r_len;
    assign bus.error           = r_error;
    assign bus.level           = r_level;
endmodule

// File: tb/tb_exp_golomb_decode.sv
// Testbench for exp_golomb_decode. A bit-queue reference model predicts in_ready, level,
// error and the emitted symbols every cycle. Directed scenarios are followed by randomized traffic.
module tb_exp_golomb_decode;
    localparam int MAX_Q = 16;

    logic clk;
    logic reset;
    exp_golomb_decode_if bus();

    exp_golomb_decode #(.MAX_Q(MAX_Q), .BUF_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: unread stream bits, oldest first.
    bit          mq[$];
    bit          mOutValid;
    bit          mSign;
    bit          mErr;
    logic [31:0] mVal;
    logic [31:0] mLen;

    // Symbols the DUT handed over, logged at handshake time.
    logic [31:0] gotVal[$];
    logic [31:0] gotLen[$];
    bit          gotSign[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle. Drive the inputs, check the combinational ready, advance the model,
    // then check the registered outputs.
    task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] word,
                                 input logic [2:0] kk, input logic ac, input logic ordy);
        int          q;
        bit          found;
        int          codeLen;
        int          need;
        bit          complete;
        bit          errDet;
        bit          fire;
        bit          expReady;
        int          sizeAfter;
        longint      sum;
        logic [31:0] nVal;
        bit          nSign;

        @(negedge clk);
        reset         = rst;
        bus.in_valid  = iv;
        bus.in_word   = word;
        bus.k         = kk;
        bus.is_ac     = ac;
        bus.out_ready = ordy;
        #1;

        found = 0;
        q     = 0;
        for (int i = 0; i <= MAX_Q && i < mq.size(); i++) begin
            if (!found && mq[i]) begin
                found = 1;
                q     = i;
            end
        end
        codeLen  = 2 * q + int'(kk) + 1;
        need     = codeLen + int'(ac);
        complete = found && (mq.size() >= need);
        errDet   = !found && (mq.size() >= MAX_Q + 1);
        fire     = complete && !mErr && (!mOutValid || ordy);
        nVal     = '0;
        nSign    = 0;
        if (fire) begin
            sum = 0;
            for (int i = 0; i < codeLen; i++) begin
                sum = (sum << 1) | longint'(mq[i]);
            end
            nVal  = 32'(sum - (longint'(1) << kk));
            nSign = ac ? mq[codeLen] : 1'b0;
        end
        sizeAfter = mq.size() - (fire ? need : 0);
        expReady  = !mErr && (sizeAfter <= 32);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));

        if (!rst && bus.out_valid && ordy) begin
            gotVal.push_back(bus.val);
            gotLen.push_back(bus.codeword_length);
            gotSign.push_back(bus.sign);
        end

        @(posedge clk);
        if (rst) begin
            mq.delete();
            mOutValid = 0;
            mSign     = 0;
            mErr      = 0;
            mVal      = '0;
            mLen      = '0;
        end else begin
            if (fire) begin
                repeat (need) void'(mq.pop_front());
                mOutValid = 1;
                mVal      = nVal;
                mSign     = nSign;
                mLen      = 32'(need);
            end else if (ordy) begin
                mOutValid = 0;
            end
            if (errDet) mErr = 1;
            if (iv && expReady) begin
                for (int b = 31; b >= 0; b--) mq.push_back(word[b]);
            end
        end
        #1;
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mOutValid));
        checkOutput("level", 32'(bus.level), 32'(mq.size()));
        checkOutput("error", 32'(bus.error), 32'(mErr));
        if (mOutValid) begin
            checkOutput("val", bus.val, mVal);
            checkOutput("sign", 32'(bus.sign), 32'(mSign));
            checkOutput("codeword_length", bus.codeword_length, mLen);
        end
    endtask

    task automatic idle(input int n, input logic [2:0] kk, input logic ac, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, kk, ac, ordy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
        gotVal.delete();
        gotLen.delete();
        gotSign.delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] w;
    logic [2:0]  curK;
    logic        curAc;
    logic        rndRst;

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.k         = '0;
        bus.is_ac     = 1'b0;
        bus.out_ready = 1'b1;
        mOutValid = 0; mSign = 0; mErr = 0; mVal = '0; mLen = '0;

        // Reset state.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
        checkOutput("rst_level", 32'(bus.level), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_val", bus.val, 32'd0);
        checkOutput("rst_len", bus.codeword_length, 32'd0);
        checkOutput("rst_error", 32'(bus.error), 32'd0);

        // Two short symbols, then a long zero run that trips the error.
        applyStimulus(1'b0, 1'b1, 32'h9000_0000, 3'd0, 1'b0, 1'b1);
        idle(8, 3'd0, 1'b0, 1'b1);
        checkOutput("t1_count", 32'(gotVal.size()), 32'd2);
        if (gotVal.size() >= 2) begin
            checkOutput("t1_val0", gotVal[0], 32'd0);
            checkOutput("t1_len0", gotLen[0], 32'd1);
            checkOutput("t1_val1", gotVal[1], 32'd3);
            checkOutput("t1_len1", gotLen[1], 32'd5);
        end
        checkOutput("t1_error", 32'(bus.error), 32'd1);
        checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd0);

        // Order k=2.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h4C00_0000, 3'd2, 1'b0, 1'b1);
        idle(6, 3'd2, 1'b0, 1'b1);
        checkOutput("t2_count", 32'(gotVal.size()), 32'd2);
        if (gotVal.size() >= 2) begin
            checkOutput("t2_val0", gotVal[0], 32'd5);
            checkOutput("t2_len0", gotLen[0], 32'd5);
            checkOutput("t2_val1", gotVal[1], 32'd0);
            checkOutput("t2_len1", gotLen[1], 32'd3);
        end

        // AC mode with a trailing sign bit.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h7000_0000, 3'd0, 1'b1, 1'b1);
        idle(4, 3'd0, 1'b1, 1'b1);
        checkOutput("t3_count", 32'(gotVal.size()), 32'd1);
        if (gotVal.size() >= 1) begin
            checkOutput("t3_val", gotVal[0], 32'd2);
            checkOutput("t3_sign", 32'(gotSign[0]), 32'd1);
            checkOutput("t3_len", gotLen[0], 32'd4);
        end

        // A codeword that spans a word boundary.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 3'd0, 1'b0, 1'b1);
        idle(35, 3'd0, 1'b0, 1'b1);
        checkOutput("t4_count_before", 32'(gotVal.size()), 32'd29);
        checkOutput("t4_level_before", 32'(bus.level), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'hD000_0000, 3'd0, 1'b0, 1'b1);
        idle(5, 3'd0, 1'b0, 1'b1);
        checkOutput("t4_count_after", 32'(gotVal.size()), 32'd30);
        if (gotVal.size() == 30) begin
            checkOutput("t4_val", gotVal[29], 32'd12);
            checkOutput("t4_len", gotLen[29], 32'd7);
        end

        // Backpressure: hold the first symbol while the buffer fills, then drain.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'hA5A5_A5A5, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hA5A5_A5A5, 3'd0, 1'b0, 1'b0);
        idle(5, 3'd0, 1'b0, 1'b0);
        checkOutput("t5_hold_level", 32'(bus.level), 32'd63);
        checkOutput("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("t5_hold_val", bus.val, 32'd0);
        checkOutput("t5_hold_len", bus.codeword_length, 32'd1);
        idle(30, 3'd0, 1'b0, 1'b1);
        if (gotVal.size() >= 3) begin
            checkOutput("t5_len0", gotLen[0], 32'd1);
            checkOutput("t5_val1", gotVal[1], 32'd1);
            checkOutput("t5_len2", gotLen[2], 32'd3);
        end else begin
            checkOutput("t5_count", 32'(gotVal.size()), 32'd3);
        end

        // Reset mid-stream while a symbol is held and the buffer is deep.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'hA5A5_A5A5, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h5A5A_5A5A, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        checkOutput("t6_level", 32'(bus.level), 32'd0);
        checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6_val", bus.val, 32'd0);
        checkOutput("t6_sign", 32'(bus.sign), 32'd0);
        checkOutput("t6_len", bus.codeword_length, 32'd0);
        checkOutput("t6_error", 32'(bus.error), 32'd0);
        gotVal.delete(); gotLen.delete(); gotSign.delete();
        applyStimulus(1'b0, 1'b1, 32'h9000_0000, 3'd0, 1'b0, 1'b1);
        idle(4, 3'd0, 1'b0, 1'b1);
        if (gotVal.size() >= 2) begin
            checkOutput("t6_restart_val1", gotVal[1], 32'd3);
        end else begin
            checkOutput("t6_restart_count", 32'(gotVal.size()), 32'd2);
        end

        // Randomized traffic: mixed bit densities, random stalls and occasional resets.
        doReset();
        curK  = 3'd0;
        curAc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rndRst = ($urandom_range(0, 199) == 0) || (mErr && ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 19) == 0) begin
                curK  = 3'($urandom_range(0, 7));
                curAc = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: w = $urandom & $urandom;
                2: w = $urandom & $urandom & $urandom & $urandom;
                default: w = 32'h8000_0000 >> $urandom_range(0, 31);
            endcase
            applyStimulus(rndRst, 1'($urandom_range(0, 9) < 7), w, curK, curAc,
                          1'($urandom_range(0, 9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
